// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART transmitter.
// Parity modes and transmit FSM states.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD,
    PAR_RSVD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider for the UART transmitter.
// Ticks in the last clock of each bit period while enabled.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == LAST);

  // Count within a bit; wrap only on the bit boundary.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: LSB first, optional parity,
// one or two stop bits, valid/ready word input.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 serial_out,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_q, two_d;
  logic                 stop2_q, stop2_d;
  logic                 so_q, so_d;
  logic                 done_q, done_d;
  logic                 busy_q;
  logic                 accept;
  logic                 tick;
  parity_t              pmode;

  assign pmode      = parity_t'(parity_mode);
  assign tx_ready   = (state_q == IDLE) && reset_n;
  assign accept     = tx_valid && tx_ready;
  assign serial_out = so_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock_i  (clock),
    .reset_n_i(reset_n),
    .clear_i  (accept),
    .enable_i (state_q != IDLE),
    .tick_o   (tick)
  );

  // Next state, line level and done pulse; line lags state by one clock.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    two_d     = two_q;
    stop2_d   = stop2_q;
    so_d      = 1'b1;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shreg_d   = tx_data;
          idx_d     = '0;
          stop2_d   = 1'b0;
          two_d     = two_stop;
          par_en_d  = (pmode == PAR_EVEN) ||
                      (pmode == PAR_ODD);
          par_bit_d = (^tx_data) ^ (pmode == PAR_ODD);
        end
      end
      START: begin
        so_d = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        so_d = shreg_q[0];
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == LAST_IDX) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        so_d = par_bit_q;
        if (tick) state_d = STOP;
      end
      STOP: begin
        so_d = 1'b1;
        if (tick) begin
          if (two_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any frame.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      idx_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      two_q     <= 1'b0;
      stop2_q   <= 1'b0;
      so_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      two_q     <= two_d;
      stop2_q   <= stop2_d;
      so_q      <= so_d;
      done_q    <= done_d;
      busy_q    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with 4 clocks per bit.
// Checks line bits per cycle plus handshake and reset behaviour.
module tb_uart_tx_frame;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic [6:0] tx_data7;
  logic       tx_valid, tx_valid7;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_ready, serial_out, busy, frame_done;
  logic       tx_ready7, serial_out7, busy7, frame_done7;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  always #5 clock = ~clock;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .serial_out (serial_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(4)) dut7 (
    .clock      (clock),
    .reset_n    (reset_n),
    .tx_data    (tx_data7),
    .tx_valid   (tx_valid7),
    .tx_ready   (tx_ready7),
    .parity_mode(parity_mode),
    .two_stop   (two_stop),
    .serial_out (serial_out7),
    .busy       (busy7),
    .frame_done (frame_done7)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic cur_ready();
    return sel != 0 ? tx_ready7 : tx_ready;
  endfunction

  function automatic logic cur_so();
    return sel != 0 ? serial_out7 : serial_out;
  endfunction

  function automatic logic cur_done();
    return sel != 0 ? frame_done7 : frame_done;
  endfunction

  // Present a word and step through the accept edge (cycle 0 after).
  task automatic send(input int s, input logic [7:0] d,
                      input logic [1:0] pm, input logic ts,
                      input bit hold);
    int n;
    sel = s;
    parity_mode = pm;
    two_stop = ts;
    if (s != 0) begin
      tx_data7 = d[6:0];
      tx_valid7 = 1'b1;
    end else begin
      tx_data = d;
      tx_valid = 1'b1;
    end
    n = 0;
    while (!cur_ready() && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("accept_timeout", 0, 1);
    step();
    if (!hold) begin
      tx_valid = 1'b0;
      tx_valid7 = 1'b0;
    end
  endtask

  // Expect each character of exp as one 4-cycle bit on the line.
  task automatic line(input string tag, input string exp);
    int nb;
    nb = exp.len();
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk(tag, cur_so(), exp[b] == 8'h31);
        chk({tag, "_done"}, cur_done(),
            (b == nb - 1) && (c == 3));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    tx_valid = 1'b0;
    tx_valid7 = 1'b0;
    tx_data = '0;
    tx_data7 = '0;
    parity_mode = 2'd0;
    two_stop = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_so", serial_out, 1);
      chk("rst_ready", tx_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
    end
    reset_n = 1'b1;
    step();
    chk("rel_ready", tx_ready, 1);
    chk("rel_ready7", tx_ready7, 1);

    send(0, 8'hA5, 2'd0, 1'b0, 1'b0);
    chk("8n1_busy", busy, 1);
    chk("8n1_ready", tx_ready, 0);
    line("8n1", "0101001011");
    step();
    chk("8n1_ready_back", tx_ready, 1);
    chk("8n1_busy_end", busy, 0);

    send(0, 8'hA5, 2'd1, 1'b0, 1'b0);
    line("8e1_a5", "01010010101");
    send(0, 8'hA5, 2'd2, 1'b0, 1'b0);
    line("8o1_a5", "01010010111");
    send(0, 8'h01, 2'd1, 1'b0, 1'b0);
    line("8e1_01", "01000000011");
    send(0, 8'hA5, 2'd3, 1'b0, 1'b0);
    line("rsvd_a5", "0101001011");

    send(1, 8'h55, 2'd0, 1'b1, 1'b0);
    line("7n2_55", "0101010111");
    step();
    chk("7n2_ready", tx_ready7, 1);

    send(0, 8'h0F, 2'd0, 1'b0, 1'b1);
    tx_data = 8'hF0;
    fork
      begin
        repeat (20) step();
        parity_mode = 2'd1;
      end
    join_none
    line("b2b_a", "0111100001");
    step();
    chk("b2b_gap", serial_out, 1);
    chk("b2b_busy", busy, 1);
    tx_valid = 1'b0;
    line("b2b_b", "00000111101");
    step();

    send(0, 8'hA5, 2'd0, 1'b0, 1'b0);
    repeat (12) step();
    reset_n = 1'b0;
    step();
    chk("mid_so", serial_out, 1);
    chk("mid_done", frame_done, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", tx_ready, 0);
    step();
    chk("mid_done2", frame_done, 0);
    reset_n = 1'b1;
    step();
    chk("mid_rel_ready", tx_ready, 1);
    chk("mid_rel_so", serial_out, 1);
    send(0, 8'h01, 2'd1, 1'b0, 1'b0);
    line("post_rst", "01000000011");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 transmitter wrapper. Serialises one DATA_BITS-wide word per frame, LSB first, with a runtime-selectable parity bit and one or two stop bits. Bit timing comes from an internal clocks-per-bit divider. Sits between the capstone message logic and the board TX pin, and takes words through a valid/ready handshake in place of the old isNew/ready pulse pair.

## Interface
- DATA_BITS, 8, payload bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2.
- clock  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  reset. One clock; reset is synchronous and active-low.
- tx_data  input  DATA_BITS  word to send; sampled on accept.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  block can accept a word.
- parity_mode  input  2  0 = none, 1 = even, 2 = odd, 3 = reserved (treated as none); sampled on accept.
- two_stop  input  1  1 = two stop bits; sampled on accept.
- serial_out  output  1  line output; idles high.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- Accept occurs on a rising edge where tx_valid && tx_ready. On accept the block latches tx_data, parity_mode and two_stop. Input changes after accept do not affect the frame.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_ready = 1, serial_out = 1. On accept, go to START.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shreg[0] for CLKS_PER_BIT cycles and shift right. The bit index counts 0..DATA_BITS-1. After the last bit, go to PARITY if the latched mode is 1 or 2; otherwise go to STOP.
  - PARITY: drive the parity bit for CLKS_PER_BIT cycles, then go to STOP. Even parity = XOR of the data bits. Odd parity = its inverse.
  - STOP: drive 1 for CLKS_PER_BIT × (two_stop ? 2 : 1) cycles, then go to IDLE. frame_done pulses in the final cycle.
- tx_ready = (state == IDLE) && reset_n. busy = (state != IDLE).
- Frame length in bits = 1 + DATA_BITS + (parity ? 1 : 0) + (two_stop ? 2 : 1).
- Bit counter width is $clog2(CLKS_PER_BIT). It clears on accept and at each bit boundary, and never wraps mid-bit.

## Timing
- While reset_n = 0 at an edge, the following hold in the next cycle:
  - state = IDLE
  - serial_out = 1
  - busy = 0
  - frame_done = 0
  - counters = 0
- tx_ready is 0 during any cycle in which reset_n is low. It is 1 in the first cycle after release.
- serial_out, busy and frame_done are registered.
- If accept happens at edge T, the start bit occupies the cycles after edges T+1 .. T+CLKS_PER_BIT, i.e. one cycle of latency.
- Reset mid-frame abandons the frame. serial_out is 1 from the next cycle. No frame_done pulse is produced.
- Back-to-back frames: IDLE always lasts at least one cycle, so the line carries at least one extra idle-high cycle between frames.
- tx_valid while busy: the word is held off (tx_ready = 0). The producer must keep tx_valid and tx_data stable until accept.
- parity_mode = 3 behaves exactly like 0.

## Structure
- Package uart_pkg holds:
  - typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_t
  - typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t
- One sub-module: uart_baud_tick, parameterised by CLKS_PER_BIT. Inputs: clear and enable. Output: a tick in the last cycle of each bit period.
- The FSM, shift register, bit index and parity generator live in uart_tx_frame.

## Test plan
- Reset/idle: hold reset_n = 0 for 3 cycles, then release. During reset, serial_out = 1, tx_ready = 0 and busy = 0. In the first cycle after release, tx_ready = 1.
- 8N1 (CLKS_PER_BIT = 4): tx_data = 0xA5. serial_out is 0,1,0,1,0,0,1,0,1,1, each bit held for 4 cycles (40 cycles). frame_done pulses in cycle 40. tx_ready returns in cycle 41.
- Parity: 0xA5 with even parity gives a parity bit of 0; with odd parity it gives 1. Frame = 11 bits = 44 cycles. Frame 0x01 with even parity gives a parity bit of 1.
- DATA_BITS = 7, two_stop = 1, tx_data = 0x55: 1 + 7 + 2 = 10 bits, with data 1,0,1,0,1,0,1. The line is high for the final 8 cycles.
- Back-to-back: hold tx_valid high with 0x0F then 0xF0. Exactly one idle-high cycle separates the frames. Changing parity_mode in mid-frame does not alter the current frame.
- Reset mid-frame: pull reset_n low during the DATA state. In the next cycle serial_out = 1, with no frame_done pulse. A new frame after release is correct.
